// File: rtl/riscv_pkg.sv
// Shared RV32I datapath definitions: data width and immediate format encodings.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned SRC_W    = 3;
    localparam int unsigned INSTR_W  = 32;

    typedef enum logic [SRC_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } immediate_type_e;

endpackage

// File: rtl/extend_immediate.sv
// RV32I immediate generator: reassembles the format-selected instruction fields,
// sign-extends to XLEN, and keeps a one-cycle registered copy for pipelined consumers.
module extend_immediate #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      imm_source,
    input  logic [XLEN-1:0] imm_instruction,
    input  logic            imm_valid,
    output logic [XLEN-1:0] imm_extended,
    output logic            imm_illegal,
    output logic [XLEN-1:0] imm_extended_q,
    output logic            imm_valid_q,
    output logic            imm_illegal_q
);
    import riscv_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] imm32;
    logic               illegal;
    logic [XLEN-1:0]    imm_extended_d;
    logic               imm_valid_d;
    logic               imm_illegal_d;

    assign instr = imm_instruction[INSTR_W-1:0];

    // Every format places the sign in bit 31 of its 32-bit reassembly, so a
    // single signed widening covers all of them for any XLEN >= 32.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        unique case (imm_source)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            default: illegal = 1'b1;
        endcase
    end

    assign imm_extended = XLEN'($signed(imm32));
    assign imm_illegal  = illegal;

    // Data/illegal registers only load on a valid beat; valid tracks every cycle.
    always_comb begin
        imm_extended_d = imm_extended_q;
        imm_illegal_d  = imm_illegal_q;
        imm_valid_d    = imm_valid;
        if (imm_valid) begin
            imm_extended_d = imm_extended;
            imm_illegal_d  = imm_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_extended_q <= '0;
            imm_valid_q    <= 1'b0;
            imm_illegal_q  <= 1'b0;
        end else begin
            imm_extended_q <= imm_extended_d;
            imm_valid_q    <= imm_valid_d;
            imm_illegal_q  <= imm_illegal_d;
        end
    end

endmodule

// File: tb/tb_extend_immediate.sv
// Self-checking bench for extend_immediate: directed RV32I examples plus random
// stimulus compared against an arithmetic immediate model.
module tb_extend_immediate;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst;
    logic [2:0]      imm_source;
    logic [XLEN-1:0] imm_instruction;
    logic            imm_valid;
    logic [XLEN-1:0] imm_extended;
    logic            imm_illegal;
    logic [XLEN-1:0] imm_extended_q;
    logic            imm_valid_q;
    logic            imm_illegal_q;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [31:0] exp_ext_q;
    logic        exp_valid_q;
    logic        exp_illegal_q;

    extend_immediate #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .imm_source     (imm_source),
        .imm_instruction(imm_instruction),
        .imm_valid      (imm_valid),
        .imm_extended   (imm_extended),
        .imm_illegal    (imm_illegal),
        .imm_extended_q (imm_extended_q),
        .imm_valid_q    (imm_valid_q),
        .imm_illegal_q  (imm_illegal_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sign-extend the low n bits of x using plain integer arithmetic.
    function automatic longint sext(input longint x, input int n);
        longint m;
        m = x & ((longint'(1) << n) - 1);
        if (((m >> (n - 1)) & 1) != 0) m = m - (longint'(1) << n);
        return m;
    endfunction

    function automatic logic [31:0] ref_imm(input int src, input logic [31:0] i);
        longint w;
        longint v;
        w = longint'(i);
        case (src)
            0: v = sext(w >> 20, 12);
            1: v = sext(((w >> 25) << 5) + ((w >> 7) & 31), 12);
            2: v = sext((((w >> 31) & 1) << 12) + (((w >> 7) & 1) << 11) +
                        (((w >> 25) & 63) << 5) + (((w >> 8) & 15) << 1), 13);
            3: v = sext((((w >> 31) & 1) << 20) + (((w >> 12) & 255) << 12) +
                        (((w >> 20) & 1) << 11) + (((w >> 21) & 1023) << 1), 21);
            4: v = (w >> 12) * 4096;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    // One cycle: drive after negedge, check combinational result, then registered result after posedge.
    task automatic step(input int src, input logic [31:0] instr, input logic vld,
                        input logic r, input logic [31:0] exp_comb);
        @(negedge clk);
        rst             = r;
        imm_source      = 3'(src);
        imm_instruction = instr;
        imm_valid       = vld;
        #1;
        check("imm_extended", imm_extended, exp_comb);
        check("imm_illegal", 32'(imm_illegal), 32'(src > 4));
        if (r) begin
            exp_ext_q     = '0;
            exp_valid_q   = 1'b0;
            exp_illegal_q = 1'b0;
        end else begin
            exp_valid_q = vld;
            if (vld) begin
                exp_ext_q     = exp_comb;
                exp_illegal_q = (src > 4);
            end
        end
        @(posedge clk);
        #1;
        check("imm_extended_q", imm_extended_q, exp_ext_q);
        check("imm_valid_q", 32'(imm_valid_q), 32'(exp_valid_q));
        check("imm_illegal_q", 32'(imm_illegal_q), 32'(exp_illegal_q));
    endtask

    initial begin
        int          src;
        logic [31:0] instr;
        logic        vld;
        logic        r;

        n_checks        = 0;
        n_errors        = 0;
        exp_ext_q       = '0;
        exp_valid_q     = 1'b0;
        exp_illegal_q   = 1'b0;
        rst             = 1'b1;
        imm_source      = 3'd0;
        imm_instruction = '0;
        imm_valid       = 1'b0;

        // Reset state with valid input present
        step(0, 32'hFFF00093, 1'b1, 1'b1, 32'hFFFFFFFF);
        step(0, 32'hFFF00093, 1'b1, 1'b1, 32'hFFFFFFFF);

        // Directed examples from the ISA
        step(0, 32'hFFF00093, 1'b1, 1'b0, 32'hFFFFFFFF);
        step(0, 32'hFFF00093, 1'b0, 1'b0, 32'hFFFFFFFF);
        step(1, 32'hFE20AE23, 1'b0, 1'b0, 32'hFFFFFFFC);
        step(2, 32'hFE000EE3, 1'b1, 1'b0, 32'hFFFFFFFC);
        step(3, 32'h008000EF, 1'b1, 1'b0, 32'h00000008);
        step(4, 32'h123452B7, 1'b1, 1'b0, 32'h12345000);
        step(7, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000);
        step(5, 32'h80000000, 1'b0, 1'b0, 32'h00000000);
        step(6, 32'h12345678, 1'b1, 1'b0, 32'h00000000);
        // Mid-stream reset clears registers while comb path keeps tracking
        step(4, 32'h123452B7, 1'b1, 1'b1, 32'h12345000);
        step(1, 32'hFE20AE23, 1'b1, 1'b0, 32'hFFFFFFFC);

        // Random stimulus against the arithmetic model
        for (int k = 0; k < 300; k++) begin
            src   = int'($urandom_range(0, 7));
            instr = $urandom;
            vld   = 1'($urandom_range(0, 1));
            r     = ($urandom_range(0, 19) == 0);
            step(src, instr, vld, r, ref_imm(src, instr));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
